sprite_renderer: RTL and testbench

Parametrised sprite pixel engine for the VGA path. It replaces the fixed per-sprite example blocks with one reusable renderer. For each pixel coordinate from the VGA controller it decides whether the pixel falls inside a positioned, optionally scaled, mirrored and animated sprite. When it does, it fetches the colour index from an external synchronous sprite ROM and presents index plus hit flag to the compositor/palette stage, three cycles after the coordinate.

---
 rtl/sprite_renderer.sv | 139 +++++++++++++
 tb/tb_sprite_renderer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_renderer.sv
// Sprite pixel engine: box test, texel addressing into an external sync ROM and a
// three-edge pipeline delivering palette index plus hit flag to the compositor.
module sprite_renderer #(
    parameter int  SPR_W      = 14,
    parameter int  SPR_H      = 14,
    parameter int  FRAMES     = 1,
    parameter int  IDX_W      = 2,
    parameter int  SCALE_LOG2 = 0,
    parameter int  ANIM_DIV   = 8,
    parameter int  TRANSP_IDX = 0,
    parameter int  ADDR_W     = $clog2(SPR_W * SPR_H * FRAMES),
    localparam int FRAME_W    = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic               vga_clk,
    input  logic               Reset,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               blank,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic               flip_x,
    input  logic               flip_y,
    input  logic               enable,
    input  logic               anim_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [IDX_W-1:0]   rom_q,
    output logic [IDX_W-1:0]   pix_idx,
    output logic               pix_hit,
    output logic [FRAME_W-1:0] frame_idx
);

    localparam int BOX_W = SPR_W << SCALE_LOG2;
    localparam int BOX_H = SPR_H << SCALE_LOG2;
    localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic               r_prev_origin;
    logic [9:0]         r_ax, r_ay;
    logic               r_fx, r_fy, r_en;
    logic [DIV_W-1:0]   r_div;
    logic [FRAME_W-1:0] r_frame;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic               r_hit1, r_hit2;
    logic [IDX_W-1:0]   r_pix_idx;
    logic               r_pix_hit;

    logic               w_origin, w_tick;
    logic [9:0]         w_ax, w_ay;
    logic               w_fx, w_fy, w_en;
    logic [DIV_W-1:0]   w_div_nxt;
    logic [FRAME_W-1:0] w_frame_nxt;
    logic [10:0]        w_x_end, w_y_end;
    logic               w_in_x, w_in_y, w_hit0;
    logic [9:0]         w_tx, w_ty, w_sx, w_sy;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_opaque;

    assign w_origin = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign w_tick   = w_origin && !r_prev_origin;

    // The tick coordinate already renders with the freshly latched shadow values.
    assign w_ax = w_tick ? pos_x  : r_ax;
    assign w_ay = w_tick ? pos_y  : r_ay;
    assign w_fx = w_tick ? flip_x : r_fx;
    assign w_fy = w_tick ? flip_y : r_fy;
    assign w_en = w_tick ? enable : r_en;

    always_comb begin
        w_div_nxt   = r_div;
        w_frame_nxt = r_frame;
        if (w_tick && anim_en) begin
            if (r_div == DIV_W'(ANIM_DIV - 1)) begin
                w_div_nxt   = '0;
                w_frame_nxt = (r_frame == FRAME_W'(FRAMES - 1)) ? '0
                                                                : r_frame + FRAME_W'(1);
            end else begin
                w_div_nxt = r_div + DIV_W'(1);
            end
        end
    end

    // 11-bit bounds so sprites near the right/bottom edge clip instead of wrapping.
    assign w_x_end = {1'b0, w_ax} + 11'(BOX_W);
    assign w_y_end = {1'b0, w_ay} + 11'(BOX_H);
    assign w_in_x  = (DrawX >= w_ax) && ({1'b0, DrawX} < w_x_end);
    assign w_in_y  = (DrawY >= w_ay) && ({1'b0, DrawY} < w_y_end);
    assign w_hit0  = w_in_x && w_in_y && blank && w_en;

    assign w_tx = (DrawX - w_ax) >> SCALE_LOG2;
    assign w_ty = (DrawY - w_ay) >> SCALE_LOG2;
    assign w_sx = w_fx ? 10'(SPR_W - 1) - w_tx : w_tx;
    assign w_sy = w_fy ? 10'(SPR_H - 1) - w_ty : w_ty;

    // Modular arithmetic at ADDR_W gives the same result as truncating the full address.
    assign w_addr = ADDR_W'(w_frame_nxt) * ADDR_W'(SPR_W * SPR_H)
                  + ADDR_W'(w_sy) * ADDR_W'(SPR_W)
                  + ADDR_W'(w_sx);

    assign w_opaque = r_hit2 && (rom_q != IDX_W'(TRANSP_IDX));

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_prev_origin <= 1'b0;
            r_ax          <= '0;
            r_ay          <= '0;
            r_fx          <= 1'b0;
            r_fy          <= 1'b0;
            r_en          <= 1'b0;
            r_div         <= '0;
            r_frame       <= '0;
            r_rom_addr    <= '0;
            r_hit1        <= 1'b0;
            r_hit2        <= 1'b0;
            r_pix_idx     <= '0;
            r_pix_hit     <= 1'b0;
        end else begin
            r_prev_origin <= w_origin;
            if (w_tick) begin
                r_ax <= pos_x;
                r_ay <= pos_y;
                r_fx <= flip_x;
                r_fy <= flip_y;
                r_en <= enable;
            end
            r_div      <= w_div_nxt;
            r_frame    <= w_frame_nxt;
            r_rom_addr <= w_hit0 ? w_addr : '0;
            r_hit1     <= w_hit0;
            r_hit2     <= r_hit1;
            r_pix_hit  <= w_opaque;
            r_pix_idx  <= w_opaque ? rom_q : '0;
        end
    end

    assign rom_addr  = r_rom_addr;
    assign pix_idx   = r_pix_idx;
    assign pix_hit   = r_pix_hit;
    assign frame_idx = r_frame;

endmodule

// File: tb/tb_sprite_renderer.sv
// Bench for sprite_renderer: two configurations driven in lockstep, checked every
// cycle against a coordinate-level reference model, plus hand-computed expectations.
module tb_sprite_renderer;

    localparam int P_FRAMES [2] = '{1, 4};
    localparam int P_DIV    [2] = '{8, 2};
    localparam int P_SCALE  [2] = '{0, 1};
    localparam int P_AW     [2] = '{8, 10};

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] draw_x, draw_y, pos_x, pos_y;
    logic       blank, flip_x, flip_y, en, anim_en;

    logic [7:0] rom_addr0;
    logic [9:0] rom_addr1;
    logic [1:0] rom_q0, rom_q1, pix_idx0, pix_idx1;
    logic       pix_hit0, pix_hit1;
    logic [0:0] frame0;
    logic [1:0] frame1;

    logic [1:0] rom_mem [2][1024];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_prev, m_ax, m_ay, m_fx, m_fy, m_en;
    int m_frame [2], m_div [2], e_addr [2];
    int s1_idx [2], s1_hit [2], s2_idx [2], s2_hit [2], o_idx [2], o_hit [2];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_q0 <= rom_mem[0][rom_addr0];
        rom_q1 <= rom_mem[1][rom_addr1];
    end

    sprite_renderer dut0 (
        .vga_clk(clk), .Reset(rst), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
        .pos_x(pos_x), .pos_y(pos_y), .flip_x(flip_x), .flip_y(flip_y), .enable(en),
        .anim_en(anim_en), .rom_addr(rom_addr0), .rom_q(rom_q0), .pix_idx(pix_idx0),
        .pix_hit(pix_hit0), .frame_idx(frame0)
    );

    sprite_renderer #(
        .FRAMES(4), .ANIM_DIV(2), .SCALE_LOG2(1)
    ) dut1 (
        .vga_clk(clk), .Reset(rst), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
        .pos_x(pos_x), .pos_y(pos_y), .flip_x(flip_x), .flip_y(flip_y), .enable(en),
        .anim_en(anim_en), .rom_addr(rom_addr1), .rom_q(rom_q1), .pix_idx(pix_idx1),
        .pix_hit(pix_hit1), .frame_idx(frame1)
    );

    function automatic void chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endfunction

    // Predict the effect of the coming clock edge on every DUT output.
    function automatic void model_advance();
        int x, y, org, tick, bw, bh, sx, sy, addr, hit0, idx;
        x = int'(draw_x);
        y = int'(draw_y);
        if (rst) begin
            m_prev = 0; m_ax = 0; m_ay = 0; m_fx = 0; m_fy = 0; m_en = 0;
            for (int d = 0; d < 2; d++) begin
                m_frame[d] = 0; m_div[d] = 0; e_addr[d] = 0;
                s1_idx[d] = 0; s1_hit[d] = 0; s2_idx[d] = 0; s2_hit[d] = 0;
                o_idx[d] = 0; o_hit[d] = 0;
            end
            return;
        end
        org    = (x == 0 && y == 0) ? 1 : 0;
        tick   = (org == 1 && m_prev == 0) ? 1 : 0;
        m_prev = org;
        if (tick == 1) begin
            m_ax = int'(pos_x); m_ay = int'(pos_y);
            m_fx = int'(flip_x); m_fy = int'(flip_y); m_en = int'(en);
            for (int d = 0; d < 2; d++) begin
                if (anim_en) begin
                    m_div[d]++;
                    if (m_div[d] == P_DIV[d]) begin
                        m_div[d]   = 0;
                        m_frame[d] = (m_frame[d] + 1) % P_FRAMES[d];
                    end
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            bw   = 14 << P_SCALE[d];
            bh   = 14 << P_SCALE[d];
            hit0 = (x >= m_ax && x < m_ax + bw && y >= m_ay && y < m_ay + bh
                    && blank && m_en == 1) ? 1 : 0;
            addr = 0;
            if (hit0 == 1) begin
                sx = (x - m_ax) >> P_SCALE[d];
                sy = (y - m_ay) >> P_SCALE[d];
                if (m_fx == 1) sx = 13 - sx;
                if (m_fy == 1) sy = 13 - sy;
                addr = (m_frame[d] * 196 + sy * 14 + sx) % (1 << P_AW[d]);
            end
            idx       = int'(rom_mem[d][addr]);
            o_idx[d]  = s2_idx[d];
            o_hit[d]  = s2_hit[d];
            s2_idx[d] = s1_idx[d];
            s2_hit[d] = s1_hit[d];
            s1_hit[d] = (hit0 == 1 && idx != 0) ? 1 : 0;
            s1_idx[d] = (s1_hit[d] == 1) ? idx : 0;
            e_addr[d] = addr;
        end
    endfunction

    function automatic void compare_model();
        chk("rom_addr0", int'(rom_addr0), e_addr[0]);
        chk("pix_hit0",  int'(pix_hit0),  o_hit[0]);
        chk("pix_idx0",  int'(pix_idx0),  o_idx[0]);
        chk("frame0",    int'(frame0),    m_frame[0]);
        chk("rom_addr1", int'(rom_addr1), e_addr[1]);
        chk("pix_hit1",  int'(pix_hit1),  o_hit[1]);
        chk("pix_idx1",  int'(pix_idx1),  o_idx[1]);
        chk("frame1",    int'(frame1),    m_frame[1]);
    endfunction

    task automatic step(input int x, input int y, input int b = 1);
        draw_x = 10'(x);
        draw_y = 10'(y);
        blank  = (b != 0);
        model_advance();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic set_shadow(input int px, input int py, input int fx, input int fy,
                              input int e);
        pos_x  = 10'(px);
        pos_y  = 10'(py);
        flip_x = (fx != 0);
        flip_y = (fy != 0);
        en     = (e != 0);
    endtask

    int seq_pre  [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    int seq_post [9] = '{0, 1, 1, 2, 2, 3, 3, 0, 0};

    initial begin
        int x, y;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 1024; i++) rom_mem[d][i] = 2'($urandom_range(0, 3));
        rom_mem[0][0] = 2'd2;
        for (int i = 1; i < 14; i++) rom_mem[0][i] = 2'd1;

        rst = 1'b1; anim_en = 1'b0;
        set_shadow(0, 0, 0, 0, 0);
        step(5, 5);
        step(6, 5);
        chk("reset_rom_addr", int'(rom_addr0), 0);
        chk("reset_pix_hit",  int'(pix_hit0),  0);
        chk("reset_pix_idx",  int'(pix_idx0),  0);
        chk("reset_frame",    int'(frame1),    0);
        rst = 1'b0;

        // Basic placement, latency and scaled box.
        set_shadow(100, 50, 0, 0, 1);
        step(0, 0);
        step(99, 50);
        step(100, 50);  chk("origin_addr", int'(rom_addr0), 0);
        step(101, 50);  chk("no_early_hit", int'(pix_hit0), 0);
        step(102, 50);
        chk("latency_idx", int'(pix_idx0), 2);
        chk("latency_hit", int'(pix_hit0), 1);
        chk("scale_sx1", int'(rom_addr1), 1);
        step(127, 50);  chk("scale_right", int'(rom_addr1), 13);
        step(128, 50);  chk("scale_out", int'(rom_addr1), 0);
        step(113, 63);  chk("corner_addr", int'(rom_addr0), 195);
        step(114, 63);  chk("past_corner", int'(rom_addr0), 0);

        // Mirroring at the screen origin.
        set_shadow(0, 0, 1, 0, 1);
        step(1, 1);
        step(0, 0);     chk("flip_x_addr", int'(rom_addr0), 13);
        flip_y = 1'b1;
        step(1, 0);
        step(0, 0);     chk("flip_xy_addr", int'(rom_addr0), 195);

        // Shadow change mid-frame only lands at the next frame tick.
        set_shadow(100, 50, 0, 0, 1);
        step(5, 5);
        step(0, 0);
        pos_x = 10'd300;
        step(101, 51);  chk("old_pos_addr", int'(rom_addr0), 15);
        step(301, 51);  chk("new_pos_early", int'(rom_addr0), 0);
        step(0, 0);
        step(301, 51);  chk("new_pos_addr", int'(rom_addr0), 15);
        step(101, 51);  chk("old_pos_gone", int'(rom_addr0), 0);

        // Clipping at the bottom-right corner, no wrap to the top-left.
        set_shadow(630, 470, 0, 0, 1);
        step(5, 5);
        step(0, 0);
        step(629, 470); chk("clip_left", int'(rom_addr0), 0);
        step(639, 479); chk("clip_corner", int'(rom_addr0), 135);
        step(639, 470); chk("clip_top", int'(rom_addr0), 9);
        step(2, 0);     chk("clip_nowrap", int'(rom_addr0), 0);

        // Animation sequence and freeze.
        rst = 1'b1; step(5, 5); rst = 1'b0;
        set_shadow(100, 50, 0, 0, 1);
        anim_en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            chk("anim_frame", int'(frame1), seq_pre[k]);
            step(0, 0);
            step(100, 50);
            chk("anim_addr", int'(rom_addr1), 196 * seq_post[k]);
        end
        anim_en = 1'b0;
        step(0, 0); step(5, 5); step(0, 0); step(5, 5);
        chk("anim_frozen", int'(frame1), 0);
        anim_en = 1'b1;
        step(0, 0);     chk("anim_resume", int'(frame1), 1);
        step(5, 5);
        anim_en = 1'b0;

        // Reset mid-sprite, then invisible until the next frame tick.
        step(0, 0);
        for (int i = 100; i < 106; i++) step(i, 50);
        chk("pre_reset_hit", int'(pix_hit0), 1);
        rst = 1'b1;
        step(106, 50);
        chk("rst_hit", int'(pix_hit0), 0);
        chk("rst_idx", int'(pix_idx0), 0);
        chk("rst_addr", int'(rom_addr0), 0);
        rst = 1'b0;
        for (int i = 107; i < 114; i++) begin
            step(i, 50);
            chk("post_rst_dark", int'(pix_hit0), 0);
        end
        step(0, 0); step(100, 50); step(101, 50); step(102, 50);
        chk("reappear_hit", int'(pix_hit0), 1);
        chk("reappear_idx", int'(pix_idx0), 2);

        // Reset beats a coinciding frame tick.
        rst = 1'b1; step(0, 0); rst = 1'b0;
        step(101, 50);  chk("rst_beats_tick", int'(rom_addr0), 0);

        // Randomised frames.
        for (int f = 0; f < 150; f++) begin
            set_shadow(int'($urandom_range(0, 650)), int'($urandom_range(0, 490)),
                       int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) != 0) ? 1 : 0);
            anim_en = ($urandom_range(0, 1) != 0);
            step(0, 0);
            for (int i = 0; i < 80; i++) begin
                rst = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 19) == 0) pos_x = 10'($urandom_range(0, 650));
                if ($urandom_range(0, 19) == 0) flip_x = ~flip_x;
                if ($urandom_range(0, 3) == 0) begin
                    x = int'($urandom_range(0, 1023));
                    y = int'($urandom_range(0, 1023));
                end else begin
                    x = m_ax + int'($urandom_range(0, 36)) - 4;
                    y = m_ay + int'($urandom_range(0, 36)) - 4;
                end
                if (x < 0) x = 0;
                if (y < 0) y = 0;
                if (x > 1023) x = 1023;
                if (y > 1023) y = 1023;
                step(x, y, ($urandom_range(0, 7) != 0) ? 1 : 0);
            end
            rst = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
